decim_chain_scheduler: RTL and testbench

Time-multiplexes a single shared FIR-and-decimate engine across a cascade of NUM_STAGES decimation stages in the PDM-to-PCM microphone path. Buffers one pending sample per stage, issues jobs to the engine one at a time, and routes each decimated result to the next stage's buffer or, after the last stage, to the chain output. Includes overrun detection and an engine watchdog.

---
 rtl/decim_chain_scheduler.sv | 163 ++++++++++++++++
 tb/tb_decim_chain_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decim_chain_scheduler.sv
// Shares one FIR-and-decimate engine across a cascade of decimation stages:
// one pending sample per stage, deepest stage served first, with overrun and watchdog flags.
module decim_chain_scheduler #(
    parameter int NUM_STAGES = 4,
    parameter int WIDTH      = 8,
    parameter int WAIT_LIMIT = 64
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            valid_in,
    input  logic signed [WIDTH-1:0]         data_in,
    output logic                            eng_start,
    output logic [$clog2(NUM_STAGES)-1:0]   eng_stage,
    output logic signed [WIDTH-1:0]         eng_data,
    input  logic                            eng_done,
    input  logic                            eng_valid,
    input  logic signed [WIDTH-1:0]         eng_result,
    output logic                            valid_out,
    output logic signed [WIDTH-1:0]         data_out,
    output logic                            overrun_out,
    output logic                            fault_out
);

    localparam int SW = $clog2(NUM_STAGES);
    localparam int WW = $clog2(WAIT_LIMIT);
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
    localparam logic [WW-1:0] WDOG_MAX   = WW'(WAIT_LIMIT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [NUM_STAGES-1:0]   pend_r;
    logic [NUM_STAGES-1:0]   pend_nxt_s;
    logic signed [WIDTH-1:0] buf_r [NUM_STAGES];
    logic [SW-1:0]           cur_r;
    logic [WW-1:0]           wdog_r;
    logic [SW-1:0]           sel_s;
    logic                    any_pend_s;
    logic                    issue_s;
    logic                    accept_s;
    logic                    timeout_s;
    logic [SW-1:0]           route_idx_s;
    logic                    route_s;
    logic                    route_ok_s;
    logic                    route_drop_s;
    logic                    final_s;
    logic                    ingress_ok_s;
    logic                    ingress_drop_s;

    // Pick the deepest pending stage so downstream buffers drain first.
    always_comb begin
        sel_s      = {SW{1'b0}};
        any_pend_s = |pend_r;
        for (int k = 0; k < NUM_STAGES; k++) begin
            sel_s = pend_r[k] ? SW'(k) : sel_s;
        end
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a done strobe in the issue cycle belongs to an older job.
    always_comb begin
        state_nxt_s = state_r;
        issue_s     = 1'b0;
        accept_s    = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_pend_s) begin
                    issue_s     = 1'b1;
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (eng_done && !eng_start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = IDLE;
                end else if (wdog_r == WDOG_MAX) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Result routing, ingress acceptance and the next pending vector.
    always_comb begin
        route_idx_s    = cur_r + SW'(1'b1);
        route_s        = accept_s && eng_valid && (cur_r != LAST_STAGE);
        final_s        = accept_s && eng_valid && (cur_r == LAST_STAGE);
        route_ok_s     = route_s && !pend_r[route_idx_s];
        route_drop_s   = route_s && pend_r[route_idx_s];
        ingress_ok_s   = valid_in && (!pend_r[0] || (issue_s && (sel_s == {SW{1'b0}})));
        ingress_drop_s = valid_in && !ingress_ok_s;
        pend_nxt_s     = pend_r;
        for (int k = 0; k < NUM_STAGES; k++) begin
            pend_nxt_s[k] = (pend_r[k] && !(issue_s && (sel_s == SW'(k))))
                          || (route_ok_s && (route_idx_s == SW'(k)))
                          || ((k == 0) && ingress_ok_s);
        end
    end

    // Buffers, job issue, watchdog and registered outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pend_r      <= {NUM_STAGES{1'b0}};
            for (int k = 0; k < NUM_STAGES; k++) begin
                buf_r[k] <= {WIDTH{1'b0}};
            end
            cur_r       <= {SW{1'b0}};
            wdog_r      <= {WW{1'b0}};
            eng_start   <= 1'b0;
            eng_stage   <= {SW{1'b0}};
            eng_data    <= {WIDTH{1'b0}};
            valid_out   <= 1'b0;
            data_out    <= {WIDTH{1'b0}};
            overrun_out <= 1'b0;
            fault_out   <= 1'b0;
        end else begin
            pend_r <= pend_nxt_s;
            if (ingress_ok_s) begin
                buf_r[0] <= data_in;
            end
            if (route_ok_s) begin
                buf_r[route_idx_s] <= eng_result;
            end
            eng_start <= issue_s;
            if (issue_s) begin
                eng_stage <= sel_s;
                eng_data  <= buf_r[sel_s];
                cur_r     <= sel_s;
                wdog_r    <= {WW{1'b0}};
            end else if (state_r == BUSY) begin
                wdog_r <= wdog_r + WW'(1'b1);
            end
            valid_out <= final_s;
            if (final_s) begin
                data_out <= eng_result;
            end
            overrun_out <= overrun_out | ingress_drop_s | route_drop_s;
            fault_out   <= fault_out | timeout_s;
        end
    end

endmodule

// File: tb/tb_decim_chain_scheduler.sv
// Scoreboard bench for decim_chain_scheduler with a behavioural mock engine
// (fixed latency, result = input + 1, optional stall / hang / per-stage decimation).
module tb_decim_chain_scheduler;

    localparam int NS  = 4;
    localparam int W   = 8;
    localparam int WL  = 16;
    localparam int LAT = 3;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          valid_in;
    logic [W-1:0]  data_in;
    logic          eng_start;
    logic [1:0]    eng_stage;
    logic [W-1:0]  eng_data;
    logic          eng_done;
    logic          eng_valid;
    logic [W-1:0]  eng_result;
    logic          valid_out;
    logic [W-1:0]  data_out;
    logic          overrun_out;
    logic          fault_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issue_cnt = 0;
    int out_cnt = 0;

    logic [9:0]   exp_issue_q [$];
    logic [W-1:0] exp_out_q [$];

    logic         stall = 1'b0;
    logic         hang = 1'b0;
    int           dec_mode = 0;
    logic [NS-1:0] eng_phase = '0;
    logic [NS-1:0] tb_phase = '0;

    decim_chain_scheduler #(.NUM_STAGES(NS), .WIDTH(W), .WAIT_LIMIT(WL)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .data_in(data_in),
        .eng_start(eng_start), .eng_stage(eng_stage), .eng_data(eng_data),
        .eng_done(eng_done), .eng_valid(eng_valid), .eng_result(eng_result),
        .valid_out(valid_out), .data_out(data_out),
        .overrun_out(overrun_out), .fault_out(fault_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        forever begin
            @(posedge clk_in);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_issue(input int st, input int d);
        exp_issue_q.push_back({2'(st), 8'(d)});
    endtask

    task automatic send(input logic [W-1:0] d);
        valid_in = 1'b1;
        data_in  = d;
        @(negedge clk_in);
        valid_in = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Mock engine: sees a job at the negedge, answers LAT negedges later.
    initial begin
        logic [1:0]   st;
        logic [W-1:0] d;
        logic         v;
        eng_done = 1'b0; eng_valid = 1'b0; eng_result = '0;
        forever begin
            @(negedge clk_in);
            if (rst_in && eng_start && !hang) begin
                st = eng_stage;
                d  = eng_data;
                repeat (LAT) @(negedge clk_in);
                while (stall) @(negedge clk_in);
                if (dec_mode == 0) begin
                    v = 1'b1;
                end else begin
                    eng_phase[st] = ~eng_phase[st];
                    v = ~eng_phase[st];
                end
                eng_valid  = v;
                eng_result = d + 8'd1;
                eng_done   = 1'b1;
                @(negedge clk_in);
                eng_done  = 1'b0;
                eng_valid = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT issues a job or emits a sample.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk_in);
            if (rst_in && eng_start) begin
                issue_cnt++;
                if (exp_issue_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL issue_unexpected: got stage %0d data %0h expected none", eng_stage, eng_data);
                end else begin
                    e = exp_issue_q.pop_front();
                    check("issue_stage_data", {eng_stage, eng_data}, e);
                end
            end
            if (rst_in && valid_out) begin
                out_cnt++;
                if (exp_out_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_unexpected: got %0h expected none", data_out);
                end else begin
                    check("data_out", data_out, exp_out_q.pop_front());
                end
            end
        end
    end

    initial begin
        int t0;
        int t1;
        int oc;
        int v;
        int r;
        bit ok;
        rst_in = 1'b0; valid_in = 1'b0; data_in = '0;

        // Reset held while valid_in toggles.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            valid_in = ~valid_in;
            data_in  = 8'(i + 8'h33);
        end
        @(negedge clk_in);
        check("rst_eng_start", eng_start, 1'b0);
        check("rst_eng_stage", eng_stage, 2'd0);
        check("rst_eng_data", eng_data, 8'h00);
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_data_out", data_out, 8'h00);
        check("rst_overrun", overrun_out, 1'b0);
        check("rst_fault", fault_out, 1'b0);
        valid_in = 1'b0;
        rst_in = 1'b1;
        wait_cycles(10);
        check("rst_no_issue", issue_cnt, 0);

        // Single sample through all stages.
        push_issue(0, 8'h10); push_issue(1, 8'h11); push_issue(2, 8'h12); push_issue(3, 8'h13);
        exp_out_q.push_back(8'h14);
        send(8'h10);
        wait_cycles(40);
        check("single_issues", issue_cnt, 4);
        check("single_outs", out_cnt, 1);
        check("single_hold", data_out, 8'h14);

        // Deepest-first: stage 2 ready alongside stage 0.
        push_issue(0, 8'h20); push_issue(1, 8'h21); push_issue(2, 8'h22); push_issue(3, 8'h23);
        push_issue(0, 8'h30); push_issue(1, 8'h31); push_issue(2, 8'h32); push_issue(3, 8'h33);
        exp_out_q.push_back(8'h24); exp_out_q.push_back(8'h34);
        send(8'h20);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (eng_start && eng_stage == 2'd1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        check("prio_wait_stage1", ok, 1'b1);
        stall = 1'b1;
        send(8'h30);
        wait_cycles(5);
        stall = 1'b0;
        wait_cycles(60);
        check("prio_issue_q_empty", exp_issue_q.size(), 0);
        check("prio_out_q_empty", exp_out_q.size(), 0);
        check("prio_no_overrun", overrun_out, 1'b0);

        // Decimation gating: every second job per stage emits.
        dec_mode = 1;
        eng_phase = '0;
        tb_phase = '0;
        oc = out_cnt;
        for (int i = 1; i <= 16; i++) begin
            v = i;
            push_issue(0, v);
            for (int k = 0; k < NS; k++) begin
                tb_phase[k] = ~tb_phase[k];
                if (tb_phase[k]) break;
                r = v + 1;
                if (k == NS - 1) begin
                    exp_out_q.push_back(8'(r));
                end else begin
                    push_issue(k + 1, r);
                    v = r;
                end
            end
            send(8'(i));
            wait_cycles(31);
        end
        check("gate_out_count", out_cnt - oc, 1);
        check("gate_hold", data_out, 8'd20);
        check("gate_issue_q_empty", exp_issue_q.size(), 0);
        dec_mode = 0;

        // Overrun: engine stalled, second queued sample dropped.
        push_issue(0, 8'h05); push_issue(1, 8'h06); push_issue(2, 8'h07); push_issue(3, 8'h08);
        push_issue(0, 8'h01); push_issue(1, 8'h02); push_issue(2, 8'h03); push_issue(3, 8'h04);
        exp_out_q.push_back(8'h09); exp_out_q.push_back(8'h05);
        stall = 1'b1;
        send(8'h05);
        wait_cycles(2);
        send(8'h01);
        check("ovr_before", overrun_out, 1'b0);
        send(8'h02);
        check("ovr_set", overrun_out, 1'b1);
        stall = 1'b0;
        wait_cycles(60);
        check("ovr_sticky", overrun_out, 1'b1);
        check("ovr_issue_q_empty", exp_issue_q.size(), 0);
        check("ovr_out_q_empty", exp_out_q.size(), 0);
        check("wd_fault_clear", fault_out, 1'b0);

        // Watchdog: engine never answers.
        hang = 1'b1;
        push_issue(0, 8'h40); push_issue(0, 8'h50);
        send(8'h40);
        ok = 1'b0;
        t0 = 0;
        for (int i = 0; i < 20; i++) begin
            if (eng_start) begin
                ok = 1'b1;
                t0 = cyc;
                break;
            end
            @(negedge clk_in);
        end
        check("wd_first_issue", ok, 1'b1);
        send(8'h50);
        ok = 1'b0;
        t1 = 0;
        for (int i = 0; i < 40; i++) begin
            if (fault_out) begin
                ok = 1'b1;
                t1 = cyc;
                break;
            end
            @(negedge clk_in);
        end
        check("wd_fault_seen", ok, 1'b1);
        check("wd_latency", t1 - t0, WL);
        wait_cycles(40);
        check("wd_next_issued", exp_issue_q.size(), 0);
        check("wd_fault_sticky", fault_out, 1'b1);
        hang = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
